// File: rtl/uart_baud_ctrl.sv
// -----------------------------------------------------------------------------
// uart_baud_ctrl
//
// Owns the UART baud divisor (BaudRate, tick period in clocks). The divisor is
// updated either by a host write, which is held pending until the link is idle,
// or by auto-baud: timing eight bit periods of a 0x55 sync character on Rx.
//
// Ports:
//   Clk            clock
//   Rst_n          asynchronous active-low reset
//   Rx             raw serial input (asynchronous, synchronized here)
//   Link_idle      TX and RX engines both idle
//   Start_autobaud one-cycle pulse, begin an auto-baud measurement
//   Cfg_we         one-cycle host divisor write strobe
//   Cfg_divisor    host divisor value
//   BaudRate       divisor to the baud generator
//   Busy           auto-baud in progress
//   Done           one-cycle pulse when auto-baud ends (success or error)
//   Locked         sticky, last auto-baud succeeded
//   Error          sticky, last auto-baud failed
//   Cfg_rejected   one-cycle pulse, host write refused
// -----------------------------------------------------------------------------
module uart_baud_ctrl #(
    parameter logic [15:0] DEFAULT_DIV = 16'd27,
    parameter int          CNT_W       = 20,
    parameter int          OVS_LOG2    = 4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Rx,
    input  logic        Link_idle,
    input  logic        Start_autobaud,
    input  logic        Cfg_we,
    input  logic [15:0] Cfg_divisor,
    output logic [15:0] BaudRate,
    output logic        Busy,
    output logic        Done,
    output logic        Locked,
    output logic        Error,
    output logic        Cfg_rejected
);

    // Wide enough for t_start*8 and for detecting a divisor above 16 bits.
    localparam int XW = (CNT_W + 4 > 17) ? CNT_W + 4 : 17;
    localparam int SH = OVS_LOG2 + 3;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [XW-1:0]    ROUND     = XW'(1) << (SH - 1);
    localparam logic [XW-1:0]    DIV_LIMIT = XW'(16'hFFFF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE,
        S_CHECK
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Rx synchronizer and edge detector
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;
    logic w_fall;
    logic w_rise;

    // Measurement datapath
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_t_start;
    logic             r_got_rise;
    logic [2:0]       r_edges;
    logic [CNT_W:0]   r_total;

    // Host write path and outputs
    logic [15:0] r_pending;
    logic        r_pend_v;
    logic [15:0] r_baud;
    logic        r_done;
    logic        r_locked;
    logic        r_error;
    logic        r_rej;

    // CHECK evaluation
    logic [XW-1:0] w_total_x;
    logic [XW-1:0] w_div_x;
    logic [XW-1:0] w_t8;
    logic [XW-1:0] w_diff;
    logic          w_check_ok;
    logic          w_last_fall;

    assign w_fall      = r_rx_prev & ~r_rx_sync;
    assign w_rise      = ~r_rx_prev & r_rx_sync;
    assign w_last_fall = w_fall && (r_edges == 3'd3);

    assign w_total_x  = XW'(r_total);
    assign w_div_x    = (w_total_x + ROUND) >> SH;
    assign w_t8       = XW'(r_t_start) << 3;
    assign w_diff     = (w_t8 >= w_total_x) ? (w_t8 - w_total_x) : (w_total_x - w_t8);
    // A start bit far from 1/8 of the span means a glitch or a non-0x55 byte.
    assign w_check_ok = (w_div_x != '0) && (w_div_x <= DIV_LIMIT) &&
                        (w_diff <= (w_total_x >> 2));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (Start_autobaud) w_state_next = S_ARM;
            S_ARM:     if (w_fall) w_state_next = S_MEASURE;
            S_MEASURE: begin
                if (w_last_fall) begin
                    w_state_next = S_CHECK;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_next = S_IDLE;
                end
            end
            S_CHECK:   w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        Busy = (r_state != S_IDLE);
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_cnt      <= '0;
            r_t_start  <= '0;
            r_got_rise <= 1'b0;
            r_edges    <= '0;
            r_total    <= '0;
            r_pending  <= '0;
            r_pend_v   <= 1'b0;
            r_baud     <= DEFAULT_DIV;
            r_done     <= 1'b0;
            r_locked   <= 1'b0;
            r_error    <= 1'b0;
            r_rej      <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_rej     <= 1'b0;
            r_rx_meta <= Rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;

            case (r_state)
                S_IDLE: begin
                    if (Start_autobaud) begin
                        r_locked <= 1'b0;
                        r_error  <= 1'b0;
                    end
                end
                S_ARM: begin
                    if (w_fall) begin
                        r_cnt      <= '0;
                        r_edges    <= '0;
                        r_t_start  <= '0;
                        r_got_rise <= 1'b0;
                    end
                end
                S_MEASURE: begin
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    // First rising edge marks the end of the start bit.
                    if (w_rise && !r_got_rise) begin
                        r_t_start  <= r_cnt;
                        r_got_rise <= 1'b1;
                    end
                    if (w_fall) begin
                        r_edges <= r_edges + 1'b1;
                    end
                    if (w_last_fall) begin
                        r_total <= {1'b0, r_cnt} + (CNT_W+1)'(1);
                    end else if (r_cnt == CNT_MAX) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
                S_CHECK: begin
                    r_done <= 1'b1;
                    if (w_check_ok) begin
                        r_baud   <= w_div_x[15:0];
                        r_locked <= 1'b1;
                    end else begin
                        r_error  <= 1'b1;
                    end
                end
                default: ;
            endcase

            // Deferred host divisor: only applied between characters.
            if (r_pend_v && Link_idle && (r_state == S_IDLE)) begin
                r_baud   <= r_pending;
                r_pend_v <= 1'b0;
                r_locked <= 1'b0;
            end
            if (Cfg_we) begin
                if ((Cfg_divisor == 16'd0) || Busy) begin
                    r_rej <= 1'b1;
                end else begin
                    r_pending <= Cfg_divisor;
                    r_pend_v  <= 1'b1;
                end
            end
            // Starting auto-baud discards any host write still waiting.
            if ((r_state == S_IDLE) && Start_autobaud) begin
                r_pend_v <= 1'b0;
            end
        end
    end

    assign BaudRate     = r_baud;
    assign Done         = r_done;
    assign Locked       = r_locked;
    assign Error        = r_error;
    assign Cfg_rejected = r_rej;

endmodule

// File: doc/uart_baud_ctrl.md
Name: uart_baud_ctrl

Overview:
Configuration controller for the UART baud-rate divisor. It owns the BaudRate[15:0] value that drives the tick generator, whose tick period is BaudRate clocks. The divisor comes from one of two sources: a host write, which is deferred until the link is idle, or an auto-baud measurement of a 0x55 sync character on Rx. It sits between the host register interface, the RX pin and the baud generator/TX/RX engines.

Parameters:
DEFAULT_DIV, 16'd27, BaudRate reset value (50 MHz, 115200 baud, x16 oversample)
CNT_W, 20, width of the measurement counter; a saturated count means timeout
OVS_LOG2, 4, log2 of the oversample factor; result shift = OVS_LOG2+3

Ports:
Clk  in  1  clock
Rst_n  in  1  asynchronous active-low reset
Rx  in  1  raw serial input, asynchronous to Clk
Link_idle  in  1  high when TX and RX engines are both idle
Start_autobaud  in  1  one-cycle pulse, begin auto-baud
Cfg_we  in  1  one-cycle host divisor write strobe
Cfg_divisor  in  16  host divisor value
BaudRate  out  16  divisor to the baud generator
Busy  out  1  auto-baud in progress
Done  out  1  one-cycle pulse when auto-baud ends (success or error)
Locked  out  1  sticky: last auto-baud succeeded
Error  out  1  sticky: last auto-baud failed
Cfg_rejected  out  1  one-cycle pulse, host write refused

Behaviour:
- Reset (async, Rst_n low): BaudRate=DEFAULT_DIV, state IDLE, pending cleared, counters 0. Busy, Done, Locked, Error and Cfg_rejected all 0. Rx synchronizer flops reset to 1.
- Rx path: 2-flop synchronizer, then a 1-flop edge detector. fall = prev&~cur. Latency is identical for every edge, so it cancels out of all measurements.
- Host write path:
  - Cfg_we with Cfg_divisor==0, or Cfg_we while Busy: Cfg_rejected pulses the next cycle. No state change.
  - Otherwise latch pending=Cfg_divisor and pend_v=1. A later write overwrites the pending value (last wins).
  - When pend_v and Link_idle and state IDLE: BaudRate<=pending on the next edge, pend_v<=0, Locked<=0.
- Auto-baud FSM, states IDLE, ARM, MEASURE, CHECK:
  - IDLE: Start_autobaud -> ARM. Clears Locked, Error and pend_v. Start while Busy is ignored.
  - ARM: wait for fall (start-bit edge). Then cnt<=0, edges<=0 -> MEASURE.
  - MEASURE: cnt increments every cycle, saturating at 2^CNT_W-1.
    - Latch t_start=cnt on the first synchronized rising edge (end of the start bit).
    - Each fall increments edges. The 4th fall (5th overall) -> CHECK with total=cnt+1, spanning 8 bit times.
    - cnt saturated -> Error=1, Done pulse -> IDLE.
  - CHECK (one cycle): div=(total + 2^(OVS_LOG2+2)) >> (OVS_LOG2+3), i.e. rounded.
    - Fail if div==0, div>16'hFFFF, or |t_start*8 - total| > total>>2 (glitch / not 0x55).
    - Fail: Error=1, BaudRate unchanged.
    - Pass: BaudRate<=div, Locked=1.
    - Done pulses in both cases -> IDLE.
- Busy=1 in ARM, MEASURE and CHECK.
- Cfg_rejected and Done are single-cycle registered pulses.
- Rx activity in IDLE has no effect.
- Reset mid-MEASURE: all state returns to reset values, and BaudRate returns to DEFAULT_DIV.

Test Plan:
- Reset -> BaudRate=27, all flags 0. Rx held high with no Start -> BaudRate stays 27.
- Start_autobaud, then 0x55 at 434 clk/bit (total=3472) -> Done after CHECK, BaudRate=(3472+64)>>7=27, Locked=1, Error=0. Repeat at 868 clk/bit -> BaudRate=54.
- Cfg_we with divisor 100 while Link_idle=0 for 50 cycles -> BaudRate stays 27. Link_idle high -> BaudRate=100 one cycle later. A second write of 120 before idle -> 120 is applied, not 100.
- Cfg_we with 0 -> Cfg_rejected pulse, BaudRate unchanged. Cfg_we during MEASURE -> Cfg_rejected, no pending value kept.
- Start, then Rx held low forever -> after 2^20-1 counts: Error=1, Done pulse, Busy=0, BaudRate unchanged.
- Start bit low for only 100 clks, remaining bits 434 clks -> CHECK fails the glitch test: Error=1, BaudRate unchanged.
- Assert Rst_n low mid-MEASURE -> BaudRate=27 and Busy=0 immediately. A new Start after release measures correctly.
